mem_access_sequencer: RTL and testbench

Multi-cycle data-memory controller between the execute stage and the 32-bit data bus. It accepts one load or store per request, encoded with the 4-bit memory-control code produced by control decode. It drives a request/acknowledge bus transaction with byte enables and stalls the pipeline until the transaction completes. It also returns sign- or zero-extended load data.

---
 rtl/mem_access_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer driving a 32-bit request/acknowledge data bus, stalling the pipeline until done.
// Optional feature: define MEM_MISALIGN_SPLIT_EN to split misaligned accesses into two beats instead of rejecting them.
module mem_access_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iValid,
    input  logic [3:0]        iMemControl,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [31:0]       iWriteData,
    output logic              oStall,
    output logic              oDone,
    output logic [31:0]       oReadData,
    output logic              oMisalign,
    output logic              oBusReq,
    output logic              oBusWe,
    output logic [ADDR_W-1:0] oBusAddr,
    output logic [31:0]       oBusWData,
    output logic [3:0]        oBusBe,
    input  logic              iBusAck,
    input  logic [31:0]       iBusRData
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} stateT;

    function automatic logic isStore(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic [3:0] sizeMask(input logic [2:0] op);
        case (op)
            OP_LW, OP_SW:         sizeMask = 4'b1111;
            OP_LH, OP_LHU, OP_SH: sizeMask = 4'b0011;
            default:              sizeMask = 4'b0001;
        endcase
    endfunction

    function automatic logic [31:0] laneMask(input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            laneMask[8*i +: 8] = {8{be[i]}};
        end
    endfunction

    function automatic logic [31:0] rotLeft(input logic [31:0] w, input logic [1:0] o);
        case (o)
            2'd0:    rotLeft = w;
            2'd1:    rotLeft = {w[23:0], w[31:24]};
            2'd2:    rotLeft = {w[15:0], w[31:16]};
            default: rotLeft = {w[7:0],  w[31:8]};
        endcase
    endfunction

    function automatic logic [31:0] rotRight(input logic [31:0] w, input logic [1:0] o);
        case (o)
            2'd0:    rotRight = w;
            2'd1:    rotRight = {w[7:0],  w[31:8]};
            2'd2:    rotRight = {w[15:0], w[31:16]};
            default: rotRight = {w[23:0], w[31:24]};
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   replicate = {4{d[7:0]}};
            OP_SH:   replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    // Expects the accessed bytes already rotated down to bit 0.
    function automatic logic [31:0] extendLoad(input logic [2:0] op, input logic [31:0] w);
        case (op)
            OP_LW:   extendLoad = w;
            OP_LH:   extendLoad = {{16{w[15]}}, w[15:0]};
            OP_LB:   extendLoad = {{24{w[7]}}, w[7:0]};
            OP_LHU:  extendLoad = {16'h0000, w[15:0]};
            OP_LBU:  extendLoad = {24'h000000, w[7:0]};
            default: extendLoad = 32'h0000_0000;
        endcase
    endfunction

    stateT       state, stateNext;
    logic        accept, reject, lastBeat;
    logic [2:0]  opIn;
    logic [1:0]  offIn;
    logic [7:0]  maskIn;
    logic [31:0] mergedRd;

    logic [2:0]  opReg;
    logic [1:0]  offReg;
    logic [3:0]  be1Reg;
    logic        misFlag;
    logic [31:0] b0Data;

    assign opIn   = iMemControl[2:0];
    assign offIn  = iAddr[1:0];
    assign accept = iRstN && (state == IDLE) && iValid && !iMemControl[3];
    // Lanes 7:4 of the shifted mask spill into the next word and form the second beat.
    assign maskIn = {4'b0000, sizeMask(opIn)} << offIn;

`ifdef MEM_MISALIGN_SPLIT_EN
    assign reject = 1'b0;
`else
    always_comb begin
        reject = 1'b0;
        case (opIn)
            OP_LW, OP_SW:         reject = (offIn != 2'b00);
            OP_LH, OP_LHU, OP_SH: reject = offIn[0];
            default:              reject = 1'b0;
        endcase
    end
`endif

    assign lastBeat = (state == BEAT1) || (be1Reg == 4'b0000);
    assign mergedRd = (be1Reg != 4'b0000) ? (b0Data | (iBusRData & laneMask(oBusBe))) : iBusRData;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        oBusReq   = 1'b0;
        oStall    = accept;
        oDone     = 1'b0;
        oMisalign = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = reject ? DONE : BEAT0;
                end
            end
            BEAT0: begin
                oBusReq = 1'b1;
                oStall  = 1'b1;
                if (iBusAck) begin
                    stateNext = (be1Reg != 4'b0000) ? BEAT1 : DONE;
                end
            end
            BEAT1: begin
                oBusReq = 1'b1;
                oStall  = 1'b1;
                if (iBusAck) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                oDone     = !misFlag;
                oMisalign = misFlag;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            opReg     <= '0;
            offReg    <= '0;
            be1Reg    <= '0;
            misFlag   <= 1'b0;
            b0Data    <= '0;
            oBusAddr  <= '0;
            oBusWData <= '0;
            oBusBe    <= '0;
            oBusWe    <= 1'b0;
            oReadData <= '0;
        end else if (accept) begin
            opReg   <= opIn;
            offReg  <= offIn;
            misFlag <= reject;
            if (reject) begin
                be1Reg    <= '0;
                oReadData <= '0;
            end else begin
                be1Reg    <= maskIn[7:4];
                oBusAddr  <= {iAddr[ADDR_W-1:2], 2'b00};
                oBusBe    <= maskIn[3:0];
                oBusWe    <= isStore(opIn);
                oBusWData <= rotLeft(replicate(opIn, iWriteData), offIn);
            end
        end else if (oBusReq && iBusAck) begin
            if (lastBeat) begin
                oReadData <= extendLoad(opReg, rotRight(mergedRd, offReg));
            end else begin
                // First half of a split access; the store data is already lane-rotated for both words.
                b0Data   <= iBusRData & laneMask(oBusBe);
                oBusAddr <= oBusAddr + ADDR_W'(4);
                oBusBe   <= be1Reg;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: directed ops push expected beats and completions, a monitor checks them.
module tb_mem_access_sequencer;
    logic        iClk = 1'b0;
    logic        iRstN = 1'b0;
    logic        iValid = 1'b0;
    logic [3:0]  iMemControl = 4'b1000;
    logic [31:0] iAddr = 32'h0;
    logic [31:0] iWriteData = 32'h0;
    logic        iBusAck = 1'b0;
    logic [31:0] iBusRData = 32'h0;
    logic        oStall, oDone, oMisalign, oBusReq, oBusWe;
    logic [31:0] oReadData, oBusAddr, oBusWData;
    logic [3:0]  oBusBe;

    mem_access_sequencer #(.ADDR_W(32)) dut (
        .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .iMemControl(iMemControl),
        .iAddr(iAddr), .iWriteData(iWriteData), .oStall(oStall), .oDone(oDone),
        .oReadData(oReadData), .oMisalign(oMisalign), .oBusReq(oBusReq), .oBusWe(oBusWe),
        .oBusAddr(oBusAddr), .oBusWData(oBusWData), .oBusBe(oBusBe),
        .iBusAck(iBusAck), .iBusRData(iBusRData)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beatT;

    typedef struct {
        logic        mis;
        logic [31:0] rd;
        int          stall;
        int          req;
    } doneT;

    beatT beatQ[$];
    doneT doneQ[$];
    int   checks = 0;
    int   fails = 0;
    int   stallRun = 0;
    int   reqRun = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic pushBeat(input logic [31:0] addr, input logic [3:0] be, input logic we, input logic [31:0] wd);
        beatT b;
        b.addr = addr; b.be = be; b.we = we; b.wdata = wd;
        beatQ.push_back(b);
    endtask

    task automatic pushDone(input logic mis, input logic [31:0] rd, input int stall, input int req);
        doneT d;
        d.mis = mis; d.rd = rd; d.stall = stall; d.req = req;
        doneQ.push_back(d);
    endtask

    // Issue one op for a single cycle, then answer nBeats bus beats after w0/w1 wait cycles.
    task automatic doOp(input logic [3:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata,
                        input int nBeats, input int w0, input int w1,
                        input logic [31:0] rd0, input logic [31:0] rd1);
        iValid = 1'b1; iMemControl = ctrl; iAddr = addr; iWriteData = wdata;
        @(posedge iClk); #1;
        iValid = 1'b0; iMemControl = 4'b1000; iAddr = 32'h0; iWriteData = 32'h0;
        for (int b = 0; b < nBeats; b++) begin
            repeat ((b == 0) ? w0 : w1) begin
                @(posedge iClk); #1;
            end
            iBusAck = 1'b1;
            iBusRData = (b == 0) ? rd0 : rd1;
            @(posedge iClk); #1;
            iBusAck = 1'b0;
            iBusRData = 32'h0;
        end
        @(posedge iClk); #1;
    endtask

    logic        prevReq = 1'b0, prevAck = 1'b0, prevWe = 1'b0;
    logic [31:0] prevAddr = 32'h0, prevWData = 32'h0;
    logic [3:0]  prevBe = 4'h0;

    initial begin : monitor
        beatT b;
        doneT d;
        forever begin
            @(negedge iClk);
            if (!iRstN) begin
                stallRun = 0;
                reqRun = 0;
                prevReq = 1'b0;
            end else begin
                if (oStall) stallRun++;
                if (oBusReq) reqRun++;
                if (oBusReq && prevReq && !prevAck) begin
                    chk("hold addr", oBusAddr, prevAddr);
                    chk("hold be", 32'(oBusBe), 32'(prevBe));
                    chk("hold we", 32'(oBusWe), 32'(prevWe));
                    chk("hold wdata", oBusWData, prevWData);
                end
                if (oBusReq && iBusAck) begin
                    if (beatQ.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL beat: unexpected beat at addr 0x%08h, expected none", oBusAddr);
                    end else begin
                        b = beatQ.pop_front();
                        chk("beat addr", oBusAddr, b.addr);
                        chk("beat be", 32'(oBusBe), 32'(b.be));
                        chk("beat we", 32'(oBusWe), 32'(b.we));
                        if (b.we) chk("beat wdata", oBusWData, b.wdata);
                    end
                end
                if (oDone || oMisalign) begin
                    if (doneQ.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL completion: unexpected done=%0b misalign=%0b, expected none", oDone, oMisalign);
                    end else begin
                        d = doneQ.pop_front();
                        chk("done/misalign", 32'({oMisalign, oDone}), d.mis ? 32'd2 : 32'd1);
                        chk("read data", oReadData, d.rd);
                        chk("stall cycles", 32'(stallRun), 32'(d.stall));
                        chk("req cycles", 32'(reqRun), 32'(d.req));
                    end
                    stallRun = 0;
                    reqRun = 0;
                end
                prevReq = oBusReq; prevAck = iBusAck; prevAddr = oBusAddr;
                prevBe = oBusBe; prevWe = oBusWe; prevWData = oBusWData;
            end
        end
    end

    task automatic chkResetState(input string tag);
        chk({tag, " stall"}, 32'(oStall), 32'd0);
        chk({tag, " done"}, 32'(oDone), 32'd0);
        chk({tag, " misalign"}, 32'(oMisalign), 32'd0);
        chk({tag, " busreq"}, 32'(oBusReq), 32'd0);
        chk({tag, " buswe"}, 32'(oBusWe), 32'd0);
        chk({tag, " busaddr"}, oBusAddr, 32'd0);
        chk({tag, " buswdata"}, oBusWData, 32'd0);
        chk({tag, " readdata"}, oReadData, 32'd0);
        chk({tag, " busbe"}, 32'(oBusBe), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge iClk);
        chkResetState("reset");
        iRstN = 1'b1;
        @(posedge iClk); #1;

        // LB with sign extension from lane 3, immediate ack
        pushBeat(32'h100, 4'b1000, 1'b0, 32'h0); pushDone(1'b0, 32'hFFFF_FF80, 2, 1);
        doOp(4'b0010, 32'h103, 32'h0, 1, 0, 0, 32'h80FF_FF00, 32'h0);
        // SH upper half with three wait cycles
        pushBeat(32'h200, 4'b1100, 1'b1, 32'hABCD_ABCD); pushDone(1'b0, 32'h0, 5, 4);
        doOp(4'b0110, 32'h202, 32'h1234_ABCD, 1, 3, 0, 32'h0, 32'h0);
        // LHU then LW back-to-back
        pushBeat(32'h10, 4'b0011, 1'b0, 32'h0); pushDone(1'b0, 32'h0000_F00F, 2, 1);
        doOp(4'b0011, 32'h10, 32'h0, 1, 0, 0, 32'h0000_F00F, 32'h0);
        pushBeat(32'h14, 4'b1111, 1'b0, 32'h0); pushDone(1'b0, 32'hDEAD_BEEF, 3, 2);
        doOp(4'b0000, 32'h14, 32'h0, 1, 1, 0, 32'hDEAD_BEEF, 32'h0);
        // LH sign extension from the upper half
        pushBeat(32'h30, 4'b1100, 1'b0, 32'h0); pushDone(1'b0, 32'hFFFF_8001, 2, 1);
        doOp(4'b0001, 32'h32, 32'h0, 1, 0, 0, 32'h8001_0000, 32'h0);
        // LBU zero extension from lane 1
        pushBeat(32'h40, 4'b0010, 1'b0, 32'h0); pushDone(1'b0, 32'h0000_009A, 2, 1);
        doOp(4'b0100, 32'h41, 32'h0, 1, 0, 0, 32'h0000_9A00, 32'h0);
        // SB replicated, two waits
        pushBeat(32'h50, 4'b0100, 1'b1, 32'h5A5A_5A5A); pushDone(1'b0, 32'h0, 4, 3);
        doOp(4'b0111, 32'h52, 32'hFFFF_FF5A, 1, 2, 0, 32'h0, 32'h0);
        // SW full word
        pushBeat(32'h60, 4'b1111, 1'b1, 32'hCAFE_F00D); pushDone(1'b0, 32'h0, 2, 1);
        doOp(4'b0101, 32'h60, 32'hCAFE_F00D, 1, 0, 0, 32'h0, 32'h0);

        // No-access code and idle cycles produce no stall
        iValid = 1'b1; iMemControl = 4'b1000; iAddr = 32'h300;
        @(negedge iClk);
        chk("no-access stall", 32'(oStall), 32'd0);
        @(posedge iClk); #1;
        iValid = 1'b0;
        @(negedge iClk);
        chk("idle busreq", 32'(oBusReq), 32'd0);
        @(posedge iClk); #1;

`ifdef MEM_MISALIGN_SPLIT_EN
        pushBeat(32'h20, 4'b1110, 1'b0, 32'h0); pushBeat(32'h24, 4'b0001, 1'b0, 32'h0);
        pushDone(1'b0, 32'h5544_3322, 3, 2);
        doOp(4'b0000, 32'h21, 32'h0, 2, 0, 0, 32'h4433_2211, 32'h0000_0055);
        pushBeat(32'h200, 4'b1000, 1'b1, 32'hEFBE_EFBE); pushBeat(32'h204, 4'b0001, 1'b1, 32'hEFBE_EFBE);
        pushDone(1'b0, 32'h0, 3, 2);
        doOp(4'b0110, 32'h203, 32'h0000_BEEF, 2, 0, 0, 32'h0, 32'h0);
        pushBeat(32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0); pushBeat(32'h0, 4'b0011, 1'b0, 32'h0);
        pushDone(1'b0, 32'hAAAA_BBBB, 5, 4);
        doOp(4'b0000, 32'hFFFF_FFFE, 32'h0, 2, 1, 1, 32'hBBBB_1234, 32'h5678_AAAA);
        pushBeat(32'h70, 4'b0110, 1'b0, 32'h0); pushDone(1'b0, 32'hFFFF_FE01, 2, 1);
        doOp(4'b0001, 32'h71, 32'h0, 1, 0, 0, 32'h00FE_0100, 32'h0);
`else
        pushDone(1'b1, 32'h0, 1, 0);
        doOp(4'b0000, 32'h21, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        pushDone(1'b1, 32'h0, 1, 0);
        doOp(4'b0110, 32'h203, 32'h0000_BEEF, 0, 0, 0, 32'h0, 32'h0);
        pushDone(1'b1, 32'h0, 1, 0);
        doOp(4'b0000, 32'hFFFF_FFFE, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        pushDone(1'b1, 32'h0, 1, 0);
        doOp(4'b0001, 32'h71, 32'h0, 0, 0, 0, 32'h0, 32'h0);
`endif

        // Reset during a BEAT0 wait aborts the access without a completion
        iValid = 1'b1; iMemControl = 4'b0000; iAddr = 32'h40;
        @(posedge iClk); #1;
        iValid = 1'b0; iMemControl = 4'b1000; iAddr = 32'h0;
        @(posedge iClk); #1;
        chk("abort req before reset", 32'(oBusReq), 32'd1);
        #2 iRstN = 1'b0;
        #1;
        chk("abort req after reset", 32'(oBusReq), 32'd0);
        chk("abort stall after reset", 32'(oStall), 32'd0);
        @(negedge iClk);
        chkResetState("abort reset");
        @(negedge iClk);
        iRstN = 1'b1;
        @(posedge iClk); #1;
        pushBeat(32'h80, 4'b1111, 1'b0, 32'h0); pushDone(1'b0, 32'h0123_4567, 2, 1);
        doOp(4'b0000, 32'h80, 32'h0, 1, 0, 0, 32'h0123_4567, 32'h0);

        repeat (3) @(posedge iClk);
        #1;
        chk("beats outstanding", 32'(beatQ.size()), 32'd0);
        chk("completions outstanding", 32'(doneQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
